uart_tx_en: RTL

8N1 UART transmitter, the transmit-side counterpart of the oversampled, enable-gated receiver.
- Serialises one byte per frame: start bit (0), 8 data bits LSB first, one stop bit (1).
- Bit timing comes from an external enable strobe `en` at Oversample × baud, so one baud generator serves both transmitter and receiver.
- Upstream side is a valid/ready byte interface; downstream side drives the serial line pin.

---
 rtl/uart_tx_en.sv | 100 ++++++++++
 1 files changed

// File: rtl/uart_tx_en.sv
// 8N1 UART transmitter paced by an external oversample enable strobe.
// Byte accepted on valid && ready; frame is start, 8 data bits LSB first, stop.
//   state | meaning
//   IDLE  | line high, waiting for a byte
//   START | driving the start bit (0)
//   DATA  | shifting out data bits LSB first
//   STOP  | driving the stop bit (1)
module uart_tx_en #(
  parameter int Oversample = 16
) (
  input  logic       clk,
  input  logic       nReset,
  input  logic       en,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       out,
  output logic       busy,
  output logic       done
);

  localparam int CW = $clog2(Oversample);
  localparam logic [CW-1:0] SAMP_MAX = CW'(Oversample - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_d;
  logic [CW-1:0] samp_cnt, samp_d;
  logic [3:0]    bit_cnt, bit_d;
  logic [7:0]    shreg, shreg_d;
  logic          out_d;
  logic          bit_end;
  logic          handshake;

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state    <= IDLE;
      samp_cnt <= SAMP_MAX;
      bit_cnt  <= 4'd8;
      shreg    <= 8'h00;
      out      <= 1'b1;
    end else begin
      state    <= state_d;
      samp_cnt <= samp_d;
      bit_cnt  <= bit_d;
      shreg    <= shreg_d;
      out      <= out_d;
    end
  end

  always_comb begin
    bit_end   = en && (samp_cnt == '0);
    ready     = (state == IDLE) || ((state == STOP) && bit_end);
    done      = (state == STOP) && bit_end;
    busy      = (state != IDLE);
    handshake = valid && ready;

    state_d = state;
    samp_d  = samp_cnt;
    bit_d   = bit_cnt;
    shreg_d = shreg;

    // the sample counter only runs while a frame is on the line
    if ((state != IDLE) && en) begin
      samp_d = bit_end ? SAMP_MAX : samp_cnt - CW'(1);
    end

    case (state)
      START: begin
        if (bit_end) state_d = DATA;
      end
      DATA: begin
        if (bit_end) begin
          shreg_d = {1'b0, shreg[7:1]};
          bit_d   = bit_cnt - 4'd1;
          if (bit_cnt == 4'd1) state_d = STOP;
        end
      end
      STOP: begin
        if (bit_end) state_d = IDLE;
      end
      default: ;
    endcase

    // a handshake on the final stop tick overrides the return to IDLE
    if (handshake) begin
      state_d = START;
      shreg_d = data;
      samp_d  = SAMP_MAX;
      bit_d   = 4'd8;
    end

    case (state)
      START:   out_d = 1'b0;
      DATA:    out_d = shreg[0];
      default: out_d = 1'b1;
    endcase
  end

endmodule
